// File: rtl/mac_tile_sched_pkg.sv
// Shared encodings and default tile geometry for the MAC tile scheduler.
package mac_tile_sched_pkg;

  typedef enum logic [1:0] {
    MODE_INT8 = 2'b00,
    MODE_INT4 = 2'b01,
    MODE_VSQ  = 2'b10,
    MODE_ILL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam int STEPS_INT8_D  = 32;
  localparam int BLOCKS_INT8_D = 8;
  localparam int STEPS_INT4_D  = 16;
  localparam int BLOCKS_INT4_D = 4;
  localparam int ROWS_D        = 16;

  function automatic logic mode_legal(input logic [1:0] m);
    return m != MODE_ILL;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_tile_sched_if.sv
// Control bus between the tile scheduler and its requester/datapath.
interface mac_tile_sched_if;
  logic       start;
  logic [1:0] mode;
  logic       ppu_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       mac_valid;
  logic       is_int8_mode;
  logic       is_int4_mode;
  logic       is_vsq;
  logic       acc_start;
  logic       acc_wr;
  logic       acc_ppu;

  modport slave (
    input  start, mode, ppu_ready,
    output busy, done, err, rd_en, rd_addr, mac_valid,
           is_int8_mode, is_int4_mode, is_vsq, acc_start, acc_wr, acc_ppu
  );

  modport master (
    output start, mode, ppu_ready,
    input  busy, done, err, rd_en, rd_addr, mac_valid,
           is_int8_mode, is_int4_mode, is_vsq, acc_start, acc_wr, acc_ppu
  );
endinterface

// File: rtl/mac_tile_sched_counter.sv
// Wrap counter with runtime terminal value; clear wins over enable.
module sched_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == last);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mac_tile_sched.sv
// Tile scheduler: walks K-blocks of MAC steps, drains accumulator rows to the
// PPU between blocks, and reports completion.
module mac_tile_sched
  import mac_tile_sched_pkg::*;
#(
  parameter int STEPS_INT8  = STEPS_INT8_D,
  parameter int BLOCKS_INT8 = BLOCKS_INT8_D,
  parameter int STEPS_INT4  = STEPS_INT4_D,
  parameter int BLOCKS_INT4 = BLOCKS_INT4_D,
  parameter int ROWS        = ROWS_D
) (
  input  logic             clk,
  input  logic             rst,
  mac_tile_sched_if.slave  bus
);

  localparam int SMAX   = (STEPS_INT8 > STEPS_INT4) ? STEPS_INT8 : STEPS_INT4;
  localparam int BMAX   = (BLOCKS_INT8 > BLOCKS_INT4) ? BLOCKS_INT8 : BLOCKS_INT4;
  localparam int SW     = cnt_w(SMAX);
  localparam int BW     = cnt_w(BMAX);
  localparam int RW     = cnt_w(ROWS);
  localparam int STAGES = 1;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic               err_q, err_d;
  logic               launch_q, launch_d;
  logic               ppu_q, ppu_d;
  logic [STAGES-1:0]  vld_pipe_q, vld_pipe_d;

  logic               step_en, step_clr, step_tc;
  logic               blk_en, blk_clr, blk_tc;
  logic               row_en, row_clr, row_tc;
  logic [SW-1:0]      step_cnt, step_last;
  logic [BW-1:0]      blk_cnt, blk_last;
  logic [RW-1:0]      row_cnt_unused;
  logic [7:0]         steps_n;
  logic               is8, rd_en;

  assign is8       = (mode_q == MODE_INT8);
  assign step_last = is8 ? SW'(STEPS_INT8 - 1)  : SW'(STEPS_INT4 - 1);
  assign blk_last  = is8 ? BW'(BLOCKS_INT8 - 1) : BW'(BLOCKS_INT4 - 1);
  assign steps_n   = is8 ? 8'(STEPS_INT8) : 8'(STEPS_INT4);

  sched_counter #(.W(SW)) u_step (
    .clk(clk), .rst(rst), .clr(step_clr), .en(step_en),
    .last(step_last), .cnt(step_cnt), .tc(step_tc)
  );

  sched_counter #(.W(BW)) u_blk (
    .clk(clk), .rst(rst), .clr(blk_clr), .en(blk_en),
    .last(blk_last), .cnt(blk_cnt), .tc(blk_tc)
  );

  sched_counter #(.W(RW)) u_row (
    .clk(clk), .rst(rst), .clr(row_clr), .en(row_en),
    .last(RW'(ROWS - 1)), .cnt(row_cnt_unused), .tc(row_tc)
  );

  // launch_q marks the acc_start cycle: still IDLE, but already committed,
  // so it counts as busy and blocks a second start.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    err_d    = err_q;
    launch_d = 1'b0;
    ppu_d    = 1'b0;
    step_en  = 1'b0;
    step_clr = 1'b0;
    blk_en   = 1'b0;
    blk_clr  = 1'b0;
    row_en   = 1'b0;
    row_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (launch_q) begin
          state_d = S_CALC;
        end else if (bus.start) begin
          if (mode_legal(bus.mode)) begin
            mode_d   = mode_e'(bus.mode);
            err_d    = 1'b0;
            launch_d = 1'b1;
            step_clr = 1'b1;
            blk_clr  = 1'b1;
            row_clr  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        step_en = 1'b1;
        if (step_tc) begin
          state_d = S_DRAIN;
          ppu_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        // First drain cycle only issues acc_ppu; rows count from the next one.
        row_en = !ppu_q && bus.ppu_ready;
        if (row_en && row_tc) begin
          blk_en  = 1'b1;
          state_d = blk_tc ? S_DONE : S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en      = (state_q == S_CALC);
  assign vld_pipe_d = STAGES'({vld_pipe_q, rd_en});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_INT8;
      err_q      <= 1'b0;
      launch_q   <= 1'b0;
      ppu_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      launch_q   <= launch_d;
      ppu_q      <= ppu_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign bus.busy         = (state_q != S_IDLE) || launch_q;
  assign bus.done         = (state_q == S_DONE);
  assign bus.err          = err_q;
  assign bus.rd_en        = rd_en;
  assign bus.rd_addr      = rd_en ? 8'(8'(blk_cnt) * steps_n + 8'(step_cnt)) : 8'd0;
  assign bus.mac_valid    = vld_pipe_q[STAGES-1];
  assign bus.acc_wr       = vld_pipe_q[STAGES-1];
  assign bus.acc_start    = launch_q;
  assign bus.acc_ppu      = ppu_q;
  assign bus.is_int8_mode = (state_q != S_IDLE) && (mode_q == MODE_INT8);
  assign bus.is_int4_mode = (state_q != S_IDLE) && (mode_q == MODE_INT4);
  assign bus.is_vsq       = (state_q != S_IDLE) && (mode_q == MODE_VSQ);

endmodule
